// File: rtl/fact_ctrl.sv
`timescale 1ns/1ps
// fact_ctrl -- control unit for the factorial accelerator datapath.
//
// Sequences an external down-counter, multiplier and product register to
// compute n! iteratively: the product register loads 1, then while the counter
// is greater than 1 the product is multiplied by the counter and the counter
// decrements. A programmable number of cycles (MUL_LAT) is allowed for the
// multiplier before each product-register load.
//
// Host handshake (four-phase Go/Done): the host raises Go and holds it; the
// unit raises Done when the result (or an error) is valid and keeps it high
// while Go stays high; the host lowers Go, and Done falls on the same edge
// that returns the unit to IDLE. Go is only sampled in IDLE to start work;
// dropping it mid-computation does not abort the sequence.
//
// Optional feature: define FACT_ERR_CHK_EN to reject n_in > N_MAX in IDLE
// (Err=1, Done=1, datapath untouched). Without it Err is constant 0.
//
// Ports:
//   Clk       rising-edge clock
//   Rst       asynchronous active-high reset
//   Go        host start request (level)
//   n_in      operand n (W bits), sampled in IDLE
//   GT_1      datapath status: counter > 1
//   Load_Cnt  load counter with n_in
//   En_Cnt    decrement counter
//   Load_Reg  product register load enable
//   Sel1      product D mux: 0 = constant 1, 1 = multiplier output
//   Sel2      output mux: 1 = product register, 0 = zero
//   Done      result valid
//   Err       illegal operand
//   CS        current state encoding (debug readback)
//
// All outputs are registered; each is set on the edge that enters the state
// it belongs to, so it is a pure function of the registered state.

module fact_ctrl #(
  parameter int W       = 4,
  parameter int MUL_LAT = 1,
  parameter int N_MAX   = 12
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Go,
  input  logic [W-1:0] n_in,
  input  logic         GT_1,
  output logic         Load_Cnt,
  output logic         En_Cnt,
  output logic         Load_Reg,
  output logic         Sel1,
  output logic         Sel2,
  output logic         Done,
  output logic         Err,
  output logic [2:0]   CS
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_MULT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Last value of the latency counter inside MULT; the load happens there.
  localparam logic [3:0] LAT_LAST = 4'(MUL_LAT - 1);
  // With a single-cycle multiplier the first MULT cycle is also the last.
  localparam bit LAST_ON_ENTRY = (MUL_LAT == 1);

  state_t     state;
  logic [3:0] lat;

`ifdef FACT_ERR_CHK_EN
  logic n_bad;
  assign n_bad = (32'(n_in) > 32'(N_MAX));
`else
  // n_in only feeds the datapath when the range check is disabled.
  logic unused_n;
  assign unused_n = ^n_in;
`endif

  assign CS = state;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= S_IDLE;
      lat      <= '0;
      Load_Cnt <= 1'b0;
      En_Cnt   <= 1'b0;
      Load_Reg <= 1'b0;
      Sel1     <= 1'b0;
      Sel2     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      // Outputs default low; each branch raises the outputs of the state
      // being entered.
      Load_Cnt <= 1'b0;
      En_Cnt   <= 1'b0;
      Load_Reg <= 1'b0;
      Sel1     <= 1'b0;
      Sel2     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (Go) begin
`ifdef FACT_ERR_CHK_EN
            if (n_bad) begin
              state <= S_ERR;
              Err   <= 1'b1;
              Done  <= 1'b1;
            end else begin
              state    <= S_INIT;
              Load_Cnt <= 1'b1;
              Load_Reg <= 1'b1;
            end
`else
            state    <= S_INIT;
            Load_Cnt <= 1'b1;
            Load_Reg <= 1'b1;
`endif
          end
        end

        S_INIT: begin
          state <= S_CHECK;
        end

        S_CHECK: begin
          if (GT_1) begin
            state <= S_MULT;
            lat   <= '0;
            Sel1  <= 1'b1;
            if (LAST_ON_ENTRY) begin
              Load_Reg <= 1'b1;
              En_Cnt   <= 1'b1;
            end
          end else begin
            state <= S_DONE;
            Done  <= 1'b1;
            Sel2  <= 1'b1;
          end
        end

        S_MULT: begin
          if (lat == LAT_LAST) begin
            // Load and decrement happened this cycle; re-test the counter.
            lat   <= '0;
            state <= S_CHECK;
          end else begin
            lat  <= lat + 4'd1;
            Sel1 <= 1'b1;
            if (4'(lat + 4'd1) == LAT_LAST) begin
              Load_Reg <= 1'b1;
              En_Cnt   <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (Go) begin
            Done <= 1'b1;
            Sel2 <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end

`ifdef FACT_ERR_CHK_EN
        S_ERR: begin
          if (Go) begin
            Err  <= 1'b1;
            Done <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
`endif

        default: begin
          // Unused encodings (and ERR when the check is compiled out).
          state <= S_IDLE;
          lat   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_ctrl.sv
`timescale 1ns/1ps
// Testbench for fact_ctrl. Two controllers share clock and reset: u0 with a
// single-cycle multiplier, u1 with MUL_LAT=3. Each drives its own behavioural
// datapath (counter, product register, combinational multiplier, output mux).

module tb_fact_ctrl;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic        go       [2];
  logic [3:0]  nv       [2];
  logic        gt_1     [2];
  logic        load_cnt [2];
  logic        en_cnt   [2];
  logic        load_reg [2];
  logic        sel1     [2];
  logic        sel2     [2];
  logic        done     [2];
  logic        err      [2];
  logic [2:0]  cs       [2];
  logic [31:0] cnt      [2];
  logic [31:0] prod     [2];
  logic [31:0] res      [2];

  fact_ctrl #(.W(4), .MUL_LAT(1), .N_MAX(12)) u0 (
    .Clk(Clk), .Rst(Rst), .Go(go[0]), .n_in(nv[0]), .GT_1(gt_1[0]),
    .Load_Cnt(load_cnt[0]), .En_Cnt(en_cnt[0]), .Load_Reg(load_reg[0]),
    .Sel1(sel1[0]), .Sel2(sel2[0]), .Done(done[0]), .Err(err[0]), .CS(cs[0])
  );

  fact_ctrl #(.W(4), .MUL_LAT(3), .N_MAX(12)) u1 (
    .Clk(Clk), .Rst(Rst), .Go(go[1]), .n_in(nv[1]), .GT_1(gt_1[1]),
    .Load_Cnt(load_cnt[1]), .En_Cnt(en_cnt[1]), .Load_Reg(load_reg[1]),
    .Sel1(sel1[1]), .Sel2(sel2[1]), .Done(done[1]), .Err(err[1]), .CS(cs[1])
  );

  // Datapath models
  for (genvar gi = 0; gi < 2; gi++) begin : g_dp
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        cnt[gi]  <= '0;
        prod[gi] <= '0;
      end else begin
        if (load_cnt[gi])    cnt[gi] <= 32'(nv[gi]);
        else if (en_cnt[gi]) cnt[gi] <= cnt[gi] - 32'd1;
        if (load_reg[gi])    prod[gi] <= sel1[gi] ? prod[gi] * cnt[gi] : 32'd1;
      end
    end
    assign gt_1[gi] = (cnt[gi] > 32'd1);
    assign res[gi]  = sel2[gi] ? prod[gi] : 32'd0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Per-run observations
  int r_cyc, r_lc, r_lr, r_lr_any, r_en, r_mult, r_ovl, r_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] outs(input int i);
    return {load_cnt[i], en_cnt[i], load_reg[i], sel1[i], sel2[i],
            done[i], err[i], cs[i]};
  endfunction

  // Called at a negedge with the unit idle. That cycle is cycle 0; returns at
  // the negedge where Done is first seen (r_cyc = cycle number, -1 on timeout).
  task automatic run(input int i, input logic [3:0] n, input int drop_at);
    nv[i] = n;
    go[i] = 1'b1;
    r_cyc = -1; r_lc = 0; r_lr = 0; r_lr_any = 0; r_en = 0;
    r_mult = 0; r_ovl = 0; r_err = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge Clk);
      if (load_cnt[i]) r_lc++;
      if (load_reg[i] && sel1[i]) r_lr++;
      if (load_reg[i]) r_lr_any++;
      if (en_cnt[i]) r_en++;
      if (cs[i] == 3'd3) r_mult++;
      if (done[i] && (load_reg[i] || load_cnt[i])) r_ovl++;
      if (err[i]) r_err = 1;
      if (c == drop_at) go[i] = 1'b0;
      if (done[i]) begin
        r_cyc = c;
        break;
      end
    end
  endtask

  task automatic release_go(input int i);
    go[i] = 1'b0;
    @(negedge Clk);
  endtask

  int held_bad;
  logic [31:0] prod_before;

  initial begin
    go[0] = 1'b0; go[1] = 1'b0;
    nv[0] = 4'd0; nv[1] = 4'd0;

    // Reset and idle
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("idle_outs_u0", 32'(outs(0)), 32'd0);
    check("idle_outs_u1", 32'(outs(1)), 32'd0);

    // n=5, single-cycle multiplier
    run(0, 4'd5, -1);
    check("n5_done_cyc", r_cyc, 11);
    check("n5_load_cnt", r_lc, 1);
    check("n5_mult_loads", r_lr, 4);
    check("n5_en_pulses", r_en, 4);
    check("n5_no_overlap", r_ovl, 0);
    check("n5_result", res[0], 120);
    release_go(0);
    check("n5_idle_cs", 32'(cs[0]), 0);
    check("n5_done_fell", 32'(done[0]), 0);

    // n=0 and n=1
    run(0, 4'd0, -1);
    check("n0_done_cyc", r_cyc, 3);
    check("n0_result", res[0], 1);
    check("n0_en_pulses", r_en, 0);
    release_go(0);
    run(0, 4'd1, -1);
    check("n1_done_cyc", r_cyc, 3);
    check("n1_result", res[0], 1);
    check("n1_en_pulses", r_en, 0);
    release_go(0);

    // MUL_LAT=3, n=4
    run(1, 4'd4, -1);
    check("l3_done_cyc", r_cyc, 15);
    check("l3_mult_cycles", r_mult, 9);
    check("l3_mult_loads", r_lr, 3);
    check("l3_en_pulses", r_en, 3);
    check("l3_result", res[1], 24);
    release_go(1);
    check("l3_idle_cs", 32'(cs[1]), 0);

    // Go dropped at cycle 4, n=6
    run(0, 4'd6, 4);
    check("drop_done_cyc", r_cyc, 13);
    check("drop_result", res[0], 720);
    @(negedge Clk);
    check("drop_done_1cyc", 32'(done[0]), 0);
    check("drop_idle_cs", 32'(cs[0]), 0);

    // Go held after Done: Done stays, no restart
    run(0, 4'd3, -1);
    check("hold_done_cyc", r_cyc, 7);
    held_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      if (!done[0] || cs[0] != 3'd4 || load_cnt[0] || load_reg[0]) held_bad++;
    end
    check("hold_stable", held_bad, 0);
    check("hold_result", res[0], 6);
    release_go(0);

    // Oversized operand
    prod_before = prod[0];
    run(0, 4'd13, -1);
`ifdef FACT_ERR_CHK_EN
    check("big_done_cyc", r_cyc, 1);
    check("big_err", 32'(err[0]), 1);
    check("big_no_load", r_lr_any, 0);
    check("big_prod_kept", prod[0], prod_before);
    check("big_bus_zero", res[0], 0);
`else
    check("big_done_cyc", r_cyc, 27);
    check("big_err", r_err, 0);
    check("big_result_wrap", res[0], 32'd1932053504);
`endif
    release_go(0);
    check("big_idle_cs", 32'(cs[0]), 0);

    // Reset asserted mid-MULT
    nv[0] = 4'd5;
    go[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (cs[0] == 3'd3) break;
    end
    check("rst_in_mult", 32'(cs[0]), 3);
    Rst = 1'b1;
    #1;
    check("rst_outs", 32'(outs(0)), 0);
    check("rst_prod", prod[0], 0);
    @(negedge Clk);
    go[0] = 1'b0;
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_stay_idle", 32'(outs(0)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fact_ctrl.md
Name: fact_ctrl

Overview:
- Control unit for the factorial accelerator datapath: sequences the down-counter, the multiplier and the product register (a loadable register with asynchronous reset).
- Uses a Go/Done four-phase handshake with the host and the GPIO I/O interface.
- Computes n! iteratively: product = 1, then product *= cnt and cnt-- while cnt > 1.
- Waits a programmable multiplier latency before each product-register load.

Parameters:
- W, 4, width of n_in and of the counter load value.
- MUL_LAT, 1, cycles the combinational/pipelined multiplier needs before its output is valid (range 1..15).
- N_MAX, 12, largest legal n (12! fits 32 bits).

Ports:
- Clk  input  1  system clock, rising-edge.
- Rst  input  1  asynchronous, active-high reset.
- Go  input  1  host start request; level, held until Done seen.
- n_in  input  W  operand n, sampled only in IDLE when Go=1.
- GT_1  input  1  datapath status: counter value > 1.
- Load_Cnt  output  1  load counter with n_in.
- En_Cnt  output  1  decrement counter by 1.
- Load_Reg  output  1  load enable of product register.
- Sel1  output  1  product register D mux: 0 = constant 1, 1 = multiplier output.
- Sel2  output  1  result output mux: 1 = drive product register to output bus, 0 = zero.
- Done  output  1  result valid.
- Err  output  1  illegal operand.
- CS  output  3  current-state encoding for debug/GPIO readback.

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0, CS=0. The latency counter clears.
- Control outputs are Moore outputs decoded from the registered state. There are no combinational paths from inputs to outputs.
- State encoding: IDLE=0, INIT=1, CHECK=2, MULT=3, DONE=4, ERR=5. Encodings 6 and 7 go to IDLE on the next edge.
- IDLE: all outputs 0. Go=1 moves to INIT, or to ERR (see Optional Feature). Go=0 stays in IDLE.
- INIT (1 cycle): Load_Cnt=1, Load_Reg=1, Sel1=0, so the counter loads n and the product loads 1. Next state CHECK.
- CHECK (1 cycle): all enables 0. GT_1=1 goes to MULT, else DONE. n=0 and n=1 therefore give result 1 after INIT and CHECK.
- MULT: Sel1=1 for the whole state. The internal latency counter lat counts 0..MUL_LAT-1.
  - While lat < MUL_LAT-1: Load_Reg=0, En_Cnt=0, lat++.
  - When lat = MUL_LAT-1: Load_Reg=1 and En_Cnt=1 in the same cycle, lat clears, next state CHECK.
  - Each iteration therefore costs MUL_LAT+1 cycles.
- DONE: Done=1, Sel2=1. The state holds while Go=1. Go=0 moves to IDLE, and Done falls in the same edge.
- ERR: Err=1, Done=1, Sel2=0. The state holds while Go=1. Go=0 moves to IDLE.
- Latency, measured from the first IDLE cycle with Go=1 to Done=1: 3 + (n-1)(MUL_LAT+1) cycles for n ≥ 2, and 3 cycles for n ≤ 1.
- Go dropped mid-computation: ignored. The sequence runs to DONE, then DONE exits on the next edge because Go=0. Done pulses for 1 cycle.
- n_in changes after IDLE: ignored, since the counter already holds the value.
- Rst asserted mid-operation: immediate return to IDLE, outputs 0. The datapath registers share Rst and clear too.
- Load_Reg and Load_Cnt are never high in the same cycle as Done.

Optional Feature:
- Macro FACT_ERR_CHK_EN.
- Defined: in IDLE with Go=1 and n_in > N_MAX, go to ERR instead of INIT. The datapath is never loaded and the product register keeps its previous value.
- Undefined: no range check. Err is tied 0, the ERR state is unreachable, and an oversized n computes with natural 32-bit wrap.

Test Plan:
- Reset/idle: Rst=1 mid-MULT with n=5 -> next sample all outputs 0, CS=0. After release with Go=0 -> stays IDLE.
- n=5, MUL_LAT=1: Go=1 held -> Load_Cnt=1 for exactly 1 cycle, 4 MULT passes (4 Load_Reg=1 with Sel1=1, 4 En_Cnt pulses), Done=1 at cycle 11. Datapath output 120. Go=0 -> IDLE next edge.
- n=0 and n=1: Done=1 at cycle 3, product 1, no En_Cnt pulses.
- MUL_LAT=3, n=4: each MULT lasts 3 cycles with a single Load_Reg/En_Cnt on the last one. Done at cycle 3+3*4=15. Result 24.
- Handshake: Go deasserted at cycle 4 with n=6 -> computation completes, Done high exactly 1 cycle, result 720. Go held high after Done -> Done stays high, no restart.
- FACT_ERR_CHK_EN defined, n_in=13 -> Err=1 and Done=1 at cycle 1, Load_Reg never asserted. Undefined -> Err stays 0 and Done arrives after 3+12*(MUL_LAT+1) cycles.
